// File: rtl/led_display_row_scheduler.sv
// HUB75 row scheduler: fetches one row per handshake, shifts it out with sclk,
// then blanks, latches, and lights the row for a fixed on-time.
//  state     | meaning
//  S_IDLE    | panel dark, waiting for enable_in
//  S_REQ     | row_ready_out raised, waiting for a row from the pattern generator
//  S_SHIFT   | columns shifted out MSB first, 2*CLK_DIV cycles per column
//  S_BLANK   | oe_n_out high before the latch
//  S_LATCH   | one-cycle latch strobe, row address updated
//  S_DISPLAY | oe_n_out low for ON_CYCLES
module led_display_row_scheduler #(
    parameter int GL_NUM_COL_PIXELS = 64,
    parameter int CLK_DIV           = 2,
    parameter int BLANK_CYCLES      = 2,
    parameter int ON_CYCLES         = 16,
    parameter int SYS_CLK_FREQ      = 100_000_000,
    localparam int GL_RGB_ROW_W     = 6 * GL_NUM_COL_PIXELS
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    enable_in,
    input  logic [GL_RGB_ROW_W-1:0] row_in,
    input  logic                    row_valid_in,
    output logic                    row_ready_out,
    output logic [2:0]              rgb_top_out,
    output logic [2:0]              rgb_bot_out,
    output logic                    sclk_out,
    output logic                    latch_out,
    output logic                    oe_n_out,
    output logic [3:0]              row_addr_out,
    output logic                    frame_done_out
);

    localparam int N     = GL_NUM_COL_PIXELS;
    localparam int COL_W = $clog2(N);
    localparam int PH_W  = $clog2(CLK_DIV + 1);
    localparam int BL_W  = $clog2(BLANK_CYCLES + 1);
    localparam int ON_W  = $clog2(ON_CYCLES + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N - 1);
    localparam logic [PH_W-1:0]  PH_INIT  = PH_W'(CLK_DIV - 1);
    localparam logic [BL_W-1:0]  BL_INIT  = BL_W'(BLANK_CYCLES - 1);
    localparam logic [ON_W-1:0]  ON_INIT  = ON_W'(ON_CYCLES - 1);

    if (N < 2 || CLK_DIV < 1 || BLANK_CYCLES < 1 || ON_CYCLES < 1 || SYS_CLK_FREQ < 1) begin : g_bad_params
        $error("led_display_row_scheduler: invalid parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_SHIFT, S_BLANK, S_LATCH, S_DISPLAY
    } state_t;

    state_t           state;
    logic [COL_W-1:0] col_cnt;
    logic [PH_W-1:0]  phase_cnt;
    logic [BL_W-1:0]  blank_cnt;
    logic [ON_W-1:0]  on_cnt;
    logic [3:0]       row_cnt;

    // Row layout, MSB first: top red, top green, top blue, bot red, bot green, bot blue.
    logic [N-1:0] in_top_r, in_top_g, in_top_b, in_bot_r, in_bot_g, in_bot_b;
    logic [N-1:0] sh_top_r, sh_top_g, sh_top_b, sh_bot_r, sh_bot_g, sh_bot_b;

    assign in_top_r = row_in[6*N-1 -: N];
    assign in_top_g = row_in[5*N-1 -: N];
    assign in_top_b = row_in[4*N-1 -: N];
    assign in_bot_r = row_in[3*N-1 -: N];
    assign in_bot_g = row_in[2*N-1 -: N];
    assign in_bot_b = row_in[N-1 -: N];

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state          <= S_IDLE;
            row_ready_out  <= 1'b0;
            rgb_top_out    <= '0;
            rgb_bot_out    <= '0;
            sclk_out       <= 1'b0;
            latch_out      <= 1'b0;
            oe_n_out       <= 1'b1;
            row_addr_out   <= '0;
            frame_done_out <= 1'b0;
            row_cnt        <= '0;
            col_cnt        <= '0;
            phase_cnt      <= '0;
            blank_cnt      <= '0;
            on_cnt         <= '0;
            sh_top_r       <= '0;
            sh_top_g       <= '0;
            sh_top_b       <= '0;
            sh_bot_r       <= '0;
            sh_bot_g       <= '0;
            sh_bot_b       <= '0;
        end else begin
            latch_out      <= 1'b0;
            frame_done_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    oe_n_out      <= 1'b1;
                    row_ready_out <= 1'b0;
                    if (enable_in) state <= S_REQ;
                end
                S_REQ: begin
                    if (row_ready_out && row_valid_in) begin
                        row_ready_out <= 1'b0;
                        rgb_top_out   <= {in_top_b[N-1], in_top_g[N-1], in_top_r[N-1]};
                        rgb_bot_out   <= {in_bot_b[N-1], in_bot_g[N-1], in_bot_r[N-1]};
                        sh_top_r      <= in_top_r << 1;
                        sh_top_g      <= in_top_g << 1;
                        sh_top_b      <= in_top_b << 1;
                        sh_bot_r      <= in_bot_r << 1;
                        sh_bot_g      <= in_bot_g << 1;
                        sh_bot_b      <= in_bot_b << 1;
                        sclk_out      <= 1'b0;
                        col_cnt       <= COL_LAST;
                        phase_cnt     <= PH_INIT;
                        state         <= S_SHIFT;
                    end else begin
                        row_ready_out <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (phase_cnt != '0) begin
                        phase_cnt <= phase_cnt - PH_W'(1);
                    end else begin
                        phase_cnt <= PH_INIT;
                        if (!sclk_out) begin
                            sclk_out <= 1'b1;
                        end else begin
                            sclk_out <= 1'b0;
                            if (col_cnt == '0) begin
                                rgb_top_out <= '0;
                                rgb_bot_out <= '0;
                                blank_cnt   <= BL_INIT;
                                state       <= S_BLANK;
                            end else begin
                                col_cnt     <= col_cnt - COL_W'(1);
                                rgb_top_out <= {sh_top_b[N-1], sh_top_g[N-1], sh_top_r[N-1]};
                                rgb_bot_out <= {sh_bot_b[N-1], sh_bot_g[N-1], sh_bot_r[N-1]};
                                sh_top_r    <= sh_top_r << 1;
                                sh_top_g    <= sh_top_g << 1;
                                sh_top_b    <= sh_top_b << 1;
                                sh_bot_r    <= sh_bot_r << 1;
                                sh_bot_g    <= sh_bot_g << 1;
                                sh_bot_b    <= sh_bot_b << 1;
                            end
                        end
                    end
                end
                S_BLANK: begin
                    if (blank_cnt != '0) begin
                        blank_cnt <= blank_cnt - BL_W'(1);
                    end else begin
                        // Address moves here so it only ever changes while the panel is dark.
                        latch_out      <= 1'b1;
                        row_addr_out   <= row_cnt;
                        frame_done_out <= (row_cnt == 4'd15);
                        row_cnt        <= row_cnt + 4'd1;
                        state          <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    oe_n_out <= 1'b0;
                    on_cnt   <= ON_INIT;
                    state    <= S_DISPLAY;
                end
                S_DISPLAY: begin
                    if (on_cnt != '0) begin
                        on_cnt <= on_cnt - ON_W'(1);
                    end else begin
                        oe_n_out <= 1'b1;
                        state    <= enable_in ? S_REQ : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
